// File: rtl/lottery_scan_ctrl_if.sv
// Number-reader handshake: the ticket reader (master) presents 5-bit numbers,
// lottery_scan_ctrl (slave) accepts them with num_ready.
interface lottery_scan_ctrl_if;
  logic       num_valid;
  logic [4:0] num_data;
  logic       num_err;
  logic       num_ready;

  modport master (
    output num_valid,
    output num_data,
    output num_err,
    input  num_ready
  );

  modport slave (
    input  num_valid,
    input  num_data,
    input  num_err,
    output num_ready
  );
endinterface

// File: rtl/lottery_scan_ctrl.sv
// Lottery round controller: loads 4 winning numbers, then per bet loads 4 bet
// numbers and strobes the bet checker once per number; sticky read-error handling.
module lottery_scan_ctrl #(
  parameter int unsigned MAX_BETS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [3:0]          n_bets,
  lottery_scan_ctrl_if.slave  rd,
  output logic [4:0]          W1,
  output logic [4:0]          W2,
  output logic [4:0]          W3,
  output logic [4:0]          W4,
  output logic [4:0]          B1,
  output logic [4:0]          B2,
  output logic [4:0]          B3,
  output logic [4:0]          B4,
  output logic                scan,
  output logic [1:0]          number,
  output logic                RD_ERR,
  output logic                busy,
  output logic                done,
  output logic [3:0]          bets_done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_W = 3'd1;
  localparam logic [2:0] LOAD_B = 3'd2;
  localparam logic [2:0] SCAN   = 3'd3;
  localparam logic [2:0] NEXT   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERR    = 3'd6;

  logic [2:0] state_q, state_d;
  logic [3:0] n_bets_q, n_bets_d;
  logic [1:0] beat_q, beat_d;
  logic [2:0] scan_cnt_q, scan_cnt_d;
  logic [3:0] bets_done_q, bets_done_d;
  logic [4:0] w_q [4];
  logic [4:0] w_d [4];
  logic [4:0] b_q [4];
  logic [4:0] b_d [4];
  logic       scan_q, scan_d;
  logic [1:0] number_q, number_d;
  logic       rd_err_q, rd_err_d;

  logic       start_ok;
  logic       beat_fire;
  logic       beat_bad;
  logic [2:0] scan_nxt;
  logic [3:0] bets_inc;

  assign start_ok  = start && (n_bets != 4'd0) && (32'(n_bets) <= MAX_BETS);
  assign rd.num_ready = (state_q == LOAD_W) || (state_q == LOAD_B);
  assign beat_fire = rd.num_valid && rd.num_ready;
  assign beat_bad  = rd.num_err || (rd.num_data == 5'd0);
  assign scan_nxt  = scan_cnt_q + 3'd1;
  assign bets_inc  = bets_done_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    n_bets_d    = n_bets_q;
    beat_d      = beat_q;
    scan_cnt_d  = scan_cnt_q;
    bets_done_d = bets_done_q;
    w_d         = w_q;
    b_d         = b_q;
    scan_d      = 1'b0;
    number_d    = number_q;
    rd_err_d    = rd_err_q;

    unique case (state_q)
      IDLE, ERR: begin
        if (start_ok) begin
          state_d     = LOAD_W;
          n_bets_d    = n_bets;
          bets_done_d = '0;
          beat_d      = '0;
          rd_err_d    = 1'b0;
        end
      end

      LOAD_W: begin
        if (beat_fire) begin
          if (beat_bad) begin
            rd_err_d = 1'b1;
            state_d  = ERR;
          end else begin
            w_d[beat_q] = rd.num_data;
            if (beat_q == 2'd3) begin
              state_d = LOAD_B;
              beat_d  = '0;
            end else begin
              beat_d = beat_q + 2'd1;
            end
          end
        end
      end

      LOAD_B: begin
        if (beat_fire) begin
          if (beat_bad) begin
            rd_err_d = 1'b1;
            state_d  = ERR;
          end else begin
            b_d[beat_q] = rd.num_data;
            if (beat_q == 2'd3) begin
              state_d    = SCAN;
              beat_d     = '0;
              scan_cnt_d = '0;
              number_d   = '0;
            end else begin
              beat_d = beat_q + 2'd1;
            end
          end
        end
      end

      // scan/number are registered one cycle ahead: the flops hold the values
      // for the SCAN cycle currently indexed by scan_cnt_q.
      SCAN: begin
        if (scan_cnt_q == 3'd7) begin
          state_d = NEXT;
        end else begin
          scan_cnt_d = scan_nxt;
          scan_d     = scan_nxt[0];
          number_d   = scan_nxt[2:1];
        end
      end

      NEXT: begin
        bets_done_d = bets_inc;
        if (bets_inc == n_bets_q) begin
          state_d = DONE;
        end else begin
          state_d = LOAD_B;
          beat_d  = '0;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      n_bets_q    <= '0;
      beat_q      <= '0;
      scan_cnt_q  <= '0;
      bets_done_q <= '0;
      w_q         <= '{default: '0};
      b_q         <= '{default: '0};
      scan_q      <= 1'b0;
      number_q    <= '0;
      rd_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_bets_q    <= n_bets_d;
      beat_q      <= beat_d;
      scan_cnt_q  <= scan_cnt_d;
      bets_done_q <= bets_done_d;
      w_q         <= w_d;
      b_q         <= b_d;
      scan_q      <= scan_d;
      number_q    <= number_d;
      rd_err_q    <= rd_err_d;
    end
  end

  assign W1        = w_q[0];
  assign W2        = w_q[1];
  assign W3        = w_q[2];
  assign W4        = w_q[3];
  assign B1        = b_q[0];
  assign B2        = b_q[1];
  assign B3        = b_q[2];
  assign B4        = b_q[3];
  assign scan      = scan_q;
  assign number    = number_q;
  assign RD_ERR    = rd_err_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign bets_done = bets_done_q;

endmodule

// File: tb/tb_lottery_scan_ctrl.sv
// Self-checking bench for lottery_scan_ctrl: randomized rounds compared against
// a per-round expectation of scan events built from the numbers sent.
module tb_lottery_scan_ctrl;
  localparam int unsigned MAX_BETS = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] n_bets;
  logic [4:0] W1, W2, W3, W4, B1, B2, B3, B4;
  logic       scan;
  logic [1:0] number;
  logic       RD_ERR, busy, done;
  logic [3:0] bets_done;

  lottery_scan_ctrl_if rd_if ();

  lottery_scan_ctrl #(.MAX_BETS(MAX_BETS)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .n_bets    (n_bets),
    .rd        (rd_if),
    .W1        (W1),
    .W2        (W2),
    .W3        (W3),
    .W4        (W4),
    .B1        (B1),
    .B2        (B2),
    .B3        (B3),
    .B4        (B4),
    .scan      (scan),
    .number    (number),
    .RD_ERR    (RD_ERR),
    .busy      (busy),
    .done      (done),
    .bets_done (bets_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [4:0] w_exp [4];
  logic [4:0] bet_tab [16][4];

  // monitor: records every scan rising edge with the number and bet on show
  longint      cyc = 0;
  longint      last_scan_cyc = 0;
  longint      done_cyc = 0;
  int          done_cnt = 0;
  logic        prev_scan = 1'b0;
  logic [1:0]  prev_number = 2'd0;
  int unsigned scan_num_q[$];
  logic [19:0] scan_b_q[$];
  bit          scan_stable_q[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (reset === 1'b1) begin
      if (scan === 1'b1 && prev_scan !== 1'b1) begin
        scan_num_q.push_back(int'(number));
        scan_b_q.push_back({B1, B2, B3, B4});
        scan_stable_q.push_back(number === prev_number);
        last_scan_cyc <= cyc;
      end
      if (done === 1'b1) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
    prev_scan   <= scan;
    prev_number <= number;
  end

  task automatic clear_mon();
    scan_num_q.delete();
    scan_b_q.delete();
    scan_stable_q.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    rd_if.num_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic do_start(input logic [3:0] n);
    @(negedge clk);
    start  = 1'b1;
    n_bets = n;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic feed_beat(input logic [4:0] d, input logic e, input int unsigned gapmax);
    int unsigned g;
    int unsigned t;
    g = (gapmax == 0) ? 0 : $urandom_range(gapmax, 0);
    @(negedge clk);
    if (g != 0) begin
      rd_if.num_valid = 1'b0;
      repeat (g) @(negedge clk);
    end
    rd_if.num_valid = 1'b1;
    rd_if.num_data  = d;
    rd_if.num_err   = e;
    t = 0;
    while (rd_if.num_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 200) begin
      errors++;
      $display("FAIL ready_timeout: waited %0d cycles, required ready within 200", t);
    end
  endtask

  task automatic random_bets(input int unsigned n);
    for (int unsigned k = 0; k < 4; k++) w_exp[k] = 5'($urandom_range(31, 1));
    for (int unsigned b = 0; b < n; b++)
      for (int unsigned k = 0; k < 4; k++) bet_tab[b][k] = 5'($urandom_range(31, 1));
  endtask

  // Drives a full legal round from bet_tab/w_exp and checks the scan stream.
  task automatic run_round(input int unsigned n, input int unsigned gapmax, input bit hold_start,
                           input string tag);
    bit got;
    int done_base;
    logic [19:0] bexp;
    clear_mon();
    done_base = done_cnt;
    do_start(4'(n));
    checks++;
    if (busy !== 1'b1 || RD_ERR !== 1'b0 || bets_done !== 4'd0) begin
      errors++;
      $display("FAIL %s_start: busy=%b rd_err=%b bets_done=%0d, required 1 0 0", tag, busy, RD_ERR,
               bets_done);
    end
    if (hold_start) begin
      start  = 1'b1;
      n_bets = 4'($urandom_range(MAX_BETS, 1));
    end
    for (int unsigned k = 0; k < 4; k++) feed_beat(w_exp[k], 1'b0, gapmax);
    for (int unsigned b = 0; b < n; b++)
      for (int unsigned k = 0; k < 4; k++) feed_beat(bet_tab[b][k], 1'b0, gapmax);
    @(negedge clk);
    rd_if.num_valid = 1'b0;
    got = 0;
    for (int t = 0; t < 600; t++) begin
      if (done === 1'b1) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_done_timeout: done not seen, required within 600 cycles", tag);
    end
    checks++;
    if (bets_done !== 4'(n)) begin
      errors++;
      $display("FAIL %s_bets_done: got %0d expected %0d", tag, bets_done, n);
    end
    checks++;
    if ({W1, W2, W3, W4} !== {w_exp[0], w_exp[1], w_exp[2], w_exp[3]}) begin
      errors++;
      $display("FAIL %s_w: got %h expected %h", tag, {W1, W2, W3, W4},
               {w_exp[0], w_exp[1], w_exp[2], w_exp[3]});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || RD_ERR !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: done=%b busy=%b rd_err=%b, required 0 0 0", tag, done, busy, RD_ERR);
    end
    checks++;
    if (done_cnt - done_base != 1) begin
      errors++;
      $display("FAIL %s_done_count: got %0d expected 1", tag, done_cnt - done_base);
    end
    checks++;
    if (scan_num_q.size() != 4 * n) begin
      errors++;
      $display("FAIL %s_scan_count: got %0d expected %0d", tag, scan_num_q.size(), 4 * n);
    end
    for (int k = 0; k < scan_num_q.size() && k < 4 * int'(n); k++) begin
      bexp = {bet_tab[k/4][0], bet_tab[k/4][1], bet_tab[k/4][2], bet_tab[k/4][3]};
      checks++;
      if (scan_num_q[k] != k % 4 || scan_b_q[k] !== bexp || !scan_stable_q[k]) begin
        errors++;
        $display("FAIL %s_scan%0d: number=%0d bets=%h stable=%0d, required %0d %h 1", tag, k,
                 scan_num_q[k], scan_b_q[k], scan_stable_q[k], k % 4, bexp);
      end
    end
    checks++;
    if (done_cyc - last_scan_cyc != 2) begin
      errors++;
      $display("FAIL %s_done_latency: got %0d cycles after last scan, required 2", tag,
               done_cyc - last_scan_cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    n_bets = 4'd0;
    rd_if.num_valid = 1'b0;
    rd_if.num_data = 5'd0;
    rd_if.num_err = 1'b0;
    #1;
    checks++;
    if ({W1, W2, W3, W4, B1, B2, B3, B4, scan, number, RD_ERR, done, bets_done, busy} !== 50'd0 ||
        rd_if.num_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: outputs=%h ready=%b, required 0 0",
               {W1, W2, W3, W4, B1, B2, B3, B4, scan, number, RD_ERR, done, bets_done, busy},
               rd_if.num_ready);
    end
    #20;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic_round();
    w_exp = '{5'd3, 5'd7, 5'd12, 5'd20};
    bet_tab[0] = '{5'd3, 5'd7, 5'd9, 5'd1};
    run_round(1, 0, 1'b0, "basic");
  endtask

  task automatic test_illegal_start();
    logic [3:0] bad [3];
    bad = '{4'd0, 4'(MAX_BETS + 1), 4'd15};
    for (int i = 0; i < 3; i++) begin
      do_start(bad[i]);
      checks++;
      if (busy !== 1'b0 || bets_done !== 4'd1 || W1 !== 5'd3 || done !== 1'b0) begin
        errors++;
        $display("FAIL illegal_start_%0d: busy=%b bets_done=%0d W1=%0d, required 0 1 3", bad[i],
                 busy, bets_done, W1);
      end
    end
  endtask

  task automatic test_gapped_round();
    random_bets(3);
    run_round(3, 3, 1'b1, "gapped");
  endtask

  task automatic test_error_mid_round();
    random_bets(3);
    clear_mon();
    do_start(4'd3);
    for (int unsigned k = 0; k < 4; k++) feed_beat(w_exp[k], 1'b0, 1);
    for (int unsigned k = 0; k < 4; k++) feed_beat(bet_tab[0][k], 1'b0, 1);
    feed_beat(bet_tab[1][0], 1'b0, 1);
    feed_beat(bet_tab[1][1], 1'b1, 0);
    @(negedge clk);
    rd_if.num_valid = 1'b0;
    rd_if.num_err = 1'b0;
    checks++;
    if (RD_ERR !== 1'b1 || rd_if.num_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL err_entry: rd_err=%b ready=%b busy=%b, required 1 0 1", RD_ERR,
               rd_if.num_ready, busy);
    end
    checks++;
    if (B1 !== bet_tab[1][0] || B2 !== bet_tab[0][1]) begin
      errors++;
      $display("FAIL err_store: B1=%0d B2=%0d, required %0d %0d", B1, B2, bet_tab[1][0],
               bet_tab[0][1]);
    end
    rd_if.num_valid = 1'b1;
    repeat (20) @(negedge clk);
    rd_if.num_valid = 1'b0;
    checks++;
    if (scan_num_q.size() != 4 || bets_done !== 4'd1 || RD_ERR !== 1'b1) begin
      errors++;
      $display("FAIL err_hold: scans=%0d bets_done=%0d rd_err=%b, required 4 1 1",
               scan_num_q.size(), bets_done, RD_ERR);
    end
    random_bets(2);
    run_round(2, 2, 1'b0, "recover");
  endtask

  task automatic test_zero_data();
    apply_reset();
    do_start(4'd1);
    feed_beat(5'd0, 1'b0, 0);
    @(negedge clk);
    rd_if.num_valid = 1'b0;
    checks++;
    if (W1 !== 5'd0 || RD_ERR !== 1'b1 || rd_if.num_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_data: W1=%0d rd_err=%b ready=%b, required 0 1 0", W1, RD_ERR,
               rd_if.num_ready);
    end
    do_start(4'd0);
    checks++;
    if (RD_ERR !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL err_illegal_start: rd_err=%b busy=%b, required 1 1", RD_ERR, busy);
    end
  endtask

  task automatic test_reset_mid_scan();
    bit found;
    apply_reset();
    random_bets(2);
    do_start(4'd2);
    for (int unsigned k = 0; k < 4; k++) feed_beat(w_exp[k], 1'b0, 0);
    for (int unsigned k = 0; k < 4; k++) feed_beat(bet_tab[0][k], 1'b0, 0);
    @(negedge clk);
    rd_if.num_valid = 1'b0;
    found = 0;
    for (int t = 0; t < 100; t++) begin
      if (scan === 1'b1 && number === 2'd2) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_scan_reach: scan high with number 2 not seen, required within 100 cycles");
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({W1, W2, W3, W4, B1, B2, B3, B4, scan, number, RD_ERR, done, bets_done, busy} !== 50'd0) begin
      errors++;
      $display("FAIL mid_scan_reset: outputs=%h, required 0",
               {W1, W2, W3, W4, B1, B2, B3, B4, scan, number, RD_ERR, done, bets_done, busy});
    end
    @(negedge clk);
    reset  = 1'b1;
    start  = 1'b1;
    n_bets = 4'd1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL first_start_after_reset: busy=%b, required 1", busy);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned n;
    apply_reset();
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(MAX_BETS, 1);
      random_bets(n);
      run_round(n, $urandom_range(2, 0), 1'($urandom_range(1, 0)), "b2b");
    end
    random_bets(MAX_BETS);
    run_round(MAX_BETS, 1, 1'b0, "max_bets");
  endtask

  initial begin
    test_reset();
    test_basic_round();
    test_illegal_start();
    test_gapped_round();
    test_error_mid_round();
    test_zero_data();
    test_reset_mid_scan();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lottery_scan_ctrl.md
LOTTERY_SCAN_CTRL -- requirements
Module: lottery_scan_ctrl

Interface
REQ-001 Parameter MAX_BETS, default 8, SHALL give the maximum bets per round; legal range 1..15.
REQ-002 clk  in  1  single system clock; all state SHALL change on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset; reset=0 SHALL force reset state immediately.
REQ-004 start  in  1  begin a round, sampled high for one clk.
REQ-005 n_bets  in  4  number of bets in the round, latched on accepted start.
REQ-006 num_valid  in  1  reader presents a number.
REQ-007 num_data  in  5  number value; 0 is illegal.
REQ-008 num_err  in  1  reader flags the presented number as corrupt.
REQ-009 num_ready  out  1  controller accepts the number; a beat transfers when num_valid & num_ready.
REQ-010 W1, W2, W3, W4  out  5 each  stored winning numbers.
REQ-011 B1, B2, B3, B4  out  5 each  stored numbers of the current bet.
REQ-012 scan  out  1  registered strobe to the bet checker, which samples on its rising edge.
REQ-013 number  out  2  index 0..3 of the number being checked.
REQ-014 RD_ERR  out  1  sticky read-error flag, high inhibits the checker.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse at round completion.
REQ-017 bets_done  out  4  count of fully scanned bets in the current round.

Function
REQ-018 States SHALL be IDLE, LOAD_W, LOAD_B, SCAN, NEXT, DONE, ERR.
REQ-019 IDLE: start=1 with 1<=n_bets<=MAX_BETS SHALL latch n_bets, clear bets_done, and go to LOAD_W; any other n_bets leaves the block in IDLE with no output change.
REQ-020 start SHALL be ignored in LOAD_W, LOAD_B, SCAN, NEXT and DONE.
REQ-021 num_ready SHALL be 1 only in LOAD_W and LOAD_B; it is combinational from state.
REQ-022 LOAD_W: the 1st..4th accepted beats SHALL write W1..W4 in order; the 4th beat SHALL move the block to LOAD_B. Duplicate values are allowed.
REQ-023 LOAD_B: the 1st..4th accepted beats SHALL write B1..B4 in order; the 4th beat SHALL move the block to SCAN. num_valid gaps SHALL stall without timeout.
REQ-024 An accepted beat with num_err=1 or num_data=0 SHALL NOT be stored; the block SHALL set RD_ERR=1 and go to ERR on the next edge.
REQ-025 SCAN SHALL last exactly 8 cycles. In cycle 2i, number=i and scan=0; in cycle 2i+1, number=i and scan=1, for i=0..3. number is therefore stable one cycle before and throughout each scan high.
REQ-026 scan and number SHALL be driven from flops, so they are glitch-free. Outside SCAN, scan=0 and number holds its last value.
REQ-027 NEXT, a single cycle, SHALL increment bets_done. If the new value equals the latched n_bets, the block goes to DONE; otherwise it goes to LOAD_B.
REQ-028 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE. W, B and bets_done SHALL hold until the next start.
REQ-029 ERR: num_ready=0, no scan pulses, and RD_ERR held at 1. start=1 with a legal n_bets SHALL clear RD_ERR, clear bets_done, latch n_bets and go to LOAD_W in one edge. Illegal start SHALL be ignored.
REQ-030 The per-bet and per-round word counters SHALL NOT wrap. The beat counter resets to 0 on entering LOAD_W and LOAD_B, and bets_done never exceeds n_bets.

Reset
REQ-031 reset=0 SHALL, asynchronously and in any state, force IDLE and drive the following outputs to 0: W1..W4, B1..B4, scan, number, RD_ERR, done, bets_done and busy. This includes mid-SCAN, where a high scan SHALL drop immediately.
REQ-032 After reset deasserts, the first start SHALL be honoured on the first rising clk edge.

Verification
REQ-033 Round n_bets=1, W=3,7,12,20, B=3,7,9,1 with num_valid always high: exactly 4 scan pulses with number 0,1,2,3; done pulses once; bets_done=1.
REQ-034 Round n_bets=3 with random num_valid gaps: exactly 12 scan pulses; B values at each scan match the sent bet; done occurs one cycle after the 3rd NEXT.
REQ-035 num_err=1 on the 2nd number of bet 2 when n_bets=3: RD_ERR=1; no further scan; bets_done=1. A following start with n_bets=2 clears RD_ERR and the round completes normally.
REQ-036 num_data=0 on the 1st winning number: ERR is entered, W1 remains 0, and num_ready drops.
REQ-037 reset pulled low during the scan-high cycle of number=2: scan=0 immediately; all outputs are 0 and busy=0.
REQ-038 start with n_bets=0, and with n_bets=MAX_BETS+1: the block stays in IDLE with busy=0. start asserted during SCAN: no effect on the pulse sequence.
